// File: rtl/eth_tx_ctrl.sv
// RMII transmit frame sequencer: emits preamble/SFD/header/payload/pad/FCS as a
// byte stream paced by the serializer's byte requests, then enforces the IFG.
module eth_tx_ctrl #(
  parameter int MIN_PAYLOAD    = 46,
  parameter int MAX_PAYLOAD    = 1500,
  parameter int IFG_BYTES      = 12,
  parameter int PREAMBLE_BYTES = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_start,
  input  logic [47:0] dest_addr,
  input  logic [47:0] src_addr,
  input  logic [15:0] len_type,
  input  logic [7:0]  data,
  input  logic        data_vld,
  input  logic        data_last,
  output logic        data_rdy,
  input  logic        byte_req,
  output logic [7:0]  tx_byte,
  output logic        tx_byte_vld,
  output logic        tx_en,
  output logic        crc_rst,
  output logic        crc_en,
  input  logic [31:0] crc_computed,
  output logic        busy,
  output logic        tx_err
);

  typedef enum logic [3:0] {
    IDLE, PREAMBLE, SFD, DEST_ADDR, SRC_ADDR, LEN_TYPE, PAYLOAD, PAD, FCS, IFG
  } state_t;

  localparam logic [4:0]  PRE_LAST = 5'(PREAMBLE_BYTES - 1);
  localparam logic [4:0]  IFG_LAST = 5'(IFG_BYTES - 1);
  localparam logic [15:0] MIN_LEN  = 16'(MIN_PAYLOAD);
  localparam logic [15:0] MAX_LEN  = 16'(MAX_PAYLOAD);

  state_t      state, state_nxt;
  logic [4:0]  cnt, cnt_nxt;
  logic [15:0] pay_cnt, pay_cnt_nxt, pay_inc;
  logic [47:0] dest_q, src_q;
  logic [15:0] len_q;
  logic [31:0] fcs_q;

  logic       emit, emit_crc, cap_fcs, latch_hdr;
  logic [7:0] emit_byte;
  logic       tx_en_nxt, err_nxt, crc_rst_nxt;

  function automatic logic [7:0] byte_of48(input logic [47:0] v, input logic [4:0] i);
    case (i)
      5'd0:    byte_of48 = v[47:40];
      5'd1:    byte_of48 = v[39:32];
      5'd2:    byte_of48 = v[31:24];
      5'd3:    byte_of48 = v[23:16];
      5'd4:    byte_of48 = v[15:8];
      default: byte_of48 = v[7:0];
    endcase
  endfunction

  assign data_rdy = byte_req && (state == PAYLOAD);
  assign pay_inc  = pay_cnt + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      pay_cnt <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pay_cnt <= pay_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pay_cnt_nxt = pay_cnt;
    emit        = 1'b0;
    emit_crc    = 1'b0;
    emit_byte   = 8'h00;
    cap_fcs     = 1'b0;
    latch_hdr   = 1'b0;
    tx_en_nxt   = tx_en;
    err_nxt     = 1'b0;
    crc_rst_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (tx_start && !busy) begin
          latch_hdr   = 1'b1;
          crc_rst_nxt = 1'b1;
          cnt_nxt     = '0;
          pay_cnt_nxt = '0;
          state_nxt   = PREAMBLE;
        end
      end
      PREAMBLE: if (byte_req) begin
        emit      = 1'b1;
        emit_byte = 8'h55;
        tx_en_nxt = 1'b1;
        if (cnt == PRE_LAST) begin
          cnt_nxt   = '0;
          state_nxt = SFD;
        end else cnt_nxt = cnt + 5'd1;
      end
      SFD: if (byte_req) begin
        emit      = 1'b1;
        emit_byte = 8'hD5;
        state_nxt = DEST_ADDR;
      end
      DEST_ADDR, SRC_ADDR: if (byte_req) begin
        emit      = 1'b1;
        emit_crc  = 1'b1;
        emit_byte = byte_of48((state == DEST_ADDR) ? dest_q : src_q, cnt);
        if (cnt == 5'd5) begin
          cnt_nxt   = '0;
          state_nxt = (state == DEST_ADDR) ? SRC_ADDR : LEN_TYPE;
        end else cnt_nxt = cnt + 5'd1;
      end
      LEN_TYPE: if (byte_req) begin
        emit      = 1'b1;
        emit_crc  = 1'b1;
        emit_byte = (cnt == 5'd0) ? len_q[15:8] : len_q[7:0];
        if (cnt == 5'd1) begin
          cnt_nxt   = '0;
          state_nxt = PAYLOAD;
        end else cnt_nxt = cnt + 5'd1;
      end
      PAYLOAD: if (byte_req) begin
        if (data_vld) begin
          emit        = 1'b1;
          emit_crc    = 1'b1;
          emit_byte   = data;
          pay_cnt_nxt = pay_inc;
          if (data_last) begin
            state_nxt = (pay_inc < MIN_LEN) ? PAD : FCS;
          end else if (pay_inc == MAX_LEN) begin
            err_nxt   = 1'b1;
            state_nxt = FCS;
          end
        end else begin
          // Underrun: abandon the frame without an FCS so the receiver sees a bad frame.
          err_nxt   = 1'b1;
          tx_en_nxt = 1'b0;
          state_nxt = IFG;
        end
      end
      PAD: if (byte_req) begin
        emit        = 1'b1;
        emit_crc    = 1'b1;
        pay_cnt_nxt = pay_inc;
        if (pay_inc == MIN_LEN) state_nxt = FCS;
      end
      FCS: if (byte_req) begin
        if (cnt < 5'd4) begin
          emit    = 1'b1;
          cnt_nxt = cnt + 5'd1;
          case (cnt)
            5'd0: begin
              emit_byte = crc_computed[7:0];
              cap_fcs   = 1'b1;
            end
            5'd1:    emit_byte = fcs_q[15:8];
            5'd2:    emit_byte = fcs_q[23:16];
            default: emit_byte = fcs_q[31:24];
          endcase
        end else begin
          tx_en_nxt = 1'b0;
          cnt_nxt   = '0;
          state_nxt = IFG;
        end
      end
      IFG: if (byte_req) begin
        if (cnt == IFG_LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else cnt_nxt = cnt + 5'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (latch_hdr) begin
      dest_q <= dest_addr;
      src_q  <= src_addr;
      len_q  <= len_type;
    end
    if (cap_fcs) fcs_q <= crc_computed;
  end

  // Busy covers the whole IFG and one extra cycle after the return to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_byte     <= '0;
      tx_byte_vld <= 1'b0;
      crc_en      <= 1'b0;
      tx_en       <= 1'b0;
      crc_rst     <= 1'b0;
      busy        <= 1'b0;
      tx_err      <= 1'b0;
    end else begin
      tx_byte_vld <= emit;
      crc_en      <= emit && emit_crc;
      tx_en       <= tx_en_nxt;
      crc_rst     <= crc_rst_nxt;
      tx_err      <= err_nxt;
      busy        <= (state != IDLE) || (state_nxt != IDLE);
      if (emit) tx_byte <= emit_byte;
      else if (state == IDLE || state == IFG) tx_byte <= '0;
    end
  end

endmodule

// File: tb/tb_eth_tx_ctrl.sv
// Scoreboard bench for eth_tx_ctrl: frames are expanded into expected byte lists
// with a software CRC32; a monitor pops and compares every emitted byte.
`timescale 1ns/1ps
module tb_eth_tx_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_start = 1'b0;
  logic [47:0] dest_addr = '0;
  logic [47:0] src_addr = '0;
  logic [15:0] len_type = '0;
  logic [7:0]  data = '0;
  logic        data_vld = 1'b0;
  logic        data_last = 1'b0;
  logic        data_rdy;
  logic        byte_req = 1'b0;
  logic [7:0]  tx_byte;
  logic        tx_byte_vld, tx_en, crc_rst, crc_en, busy, tx_err;
  logic [31:0] crc_computed;
  logic [31:0] crc_state = 32'hFFFFFFFF;

  eth_tx_ctrl dut (
    .clk(clk), .rst_n(rst_n), .tx_start(tx_start),
    .dest_addr(dest_addr), .src_addr(src_addr), .len_type(len_type),
    .data(data), .data_vld(data_vld), .data_last(data_last), .data_rdy(data_rdy),
    .byte_req(byte_req), .tx_byte(tx_byte), .tx_byte_vld(tx_byte_vld), .tx_en(tx_en),
    .crc_rst(crc_rst), .crc_en(crc_en), .crc_computed(crc_computed),
    .busy(busy), .tx_err(tx_err)
  );

  always #10 clk = ~clk;

  typedef struct packed { logic [7:0] b; logic c; } req_t;

  int nvec = 0, nerr = 0;
  req_t       exp_q[$];
  logic [7:0] src_data_q[$];
  bit  src_last = 1'b0, src_xfer = 1'b0, exp_en_on_err = 1'b0;
  int  src_idx = 0, hole = -1;
  int  bytes_popped = 0, err_seen = 0, xfers = 0, ifg_cnt = 0;

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r = c ^ {24'd0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [31:0] crc32(input logic [7:0] q[$]);
    logic [31:0] r = 32'hFFFFFFFF;
    foreach (q[i]) r = crc_upd(r, q[i]);
    return ~r;
  endfunction

  // Shared CRC engine as seen by the controller.
  always @(posedge clk) begin
    if (crc_rst) crc_state <= 32'hFFFFFFFF;
    else if (crc_en) crc_state <= crc_upd(crc_state, tx_byte);
  end
  assign crc_computed = ~crc_state;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Byte requests: one-cycle pulses at least 4 cycles apart.
  initial forever begin
    int g;
    g = $urandom_range(5, 3);
    repeat (g) @(posedge clk);
    #1 byte_req = 1'b1;
    @(posedge clk);
    #1 byte_req = 1'b0;
  end

  // Upstream payload source with an optional hole (data_vld held low) at index hole.
  initial forever begin
    @(negedge clk);
    src_xfer = data_vld & data_rdy;
    @(posedge clk);
    #1;
    if (src_xfer && src_data_q.size() > 0) begin
      void'(src_data_q.pop_front());
      src_idx++;
    end
    if (src_data_q.size() > 0 && src_idx != hole) begin
      data_vld  = 1'b1;
      data      = src_data_q[0];
      data_last = src_last && (src_data_q.size() == 1);
    end else begin
      data_vld  = 1'b0;
      data      = 8'h00;
      data_last = 1'b0;
    end
  end

  // Monitor
  initial forever begin
    req_t e;
    @(negedge clk);
    if (rst_n) begin
      if (data_rdy && data_vld) xfers++;
      if (tx_byte_vld) begin
        ifg_cnt = 0;
        if (exp_q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_byte: got %0h expected none (t=%0t)", tx_byte, $time);
        end else begin
          e = exp_q.pop_front();
          chk("tx_byte", {56'd0, tx_byte}, {56'd0, e.b});
          chk("crc_en", {63'd0, crc_en}, {63'd0, e.c});
          chk("tx_en_with_vld", {63'd0, tx_en}, 64'd1);
          bytes_popped++;
        end
      end else if (byte_req && busy && !tx_en) begin
        ifg_cnt++;
      end
      if (crc_en && !tx_byte_vld) begin
        nvec++;
        nerr++;
        $display("FAIL crc_en_without_vld: got 1 expected 0 (t=%0t)", $time);
      end
      if (tx_err) begin
        err_seen++;
        chk("tx_en_at_err", {63'd0, tx_en}, {63'd0, exp_en_on_err});
      end
    end
  end

  task automatic frame_setup(input logic [47:0] d, input logic [47:0] s, input logic [15:0] lt,
                             input int plen, input bit ramp, input bit last, input int hole_at);
    logic [7:0] pl[$];
    logic [7:0] crcb[$];
    logic [31:0] fcs;
    int n_emit;
    for (int i = 0; i < plen; i++) pl.push_back(ramp ? 8'(i) : 8'($urandom));
    exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back(req_t'({8'h55, 1'b0}));
    exp_q.push_back(req_t'({8'hD5, 1'b0}));
    for (int i = 0; i < 6; i++) crcb.push_back(d[47 - 8*i -: 8]);
    for (int i = 0; i < 6; i++) crcb.push_back(s[47 - 8*i -: 8]);
    crcb.push_back(lt[15:8]);
    crcb.push_back(lt[7:0]);
    n_emit = (hole_at >= 0) ? hole_at : ((plen > 1500) ? 1500 : plen);
    for (int i = 0; i < n_emit; i++) crcb.push_back(pl[i]);
    if (hole_at < 0) while (crcb.size() < 14 + 46) crcb.push_back(8'h00);
    foreach (crcb[i]) exp_q.push_back(req_t'({crcb[i], 1'b1}));
    if (hole_at < 0) begin
      fcs = crc32(crcb);
      for (int k = 0; k < 4; k++) exp_q.push_back(req_t'({fcs[8*k +: 8], 1'b0}));
    end
    src_data_q    = pl;
    src_last      = last;
    src_idx       = 0;
    hole          = hole_at;
    bytes_popped  = 0;
    err_seen      = 0;
    xfers         = 0;
    ifg_cnt       = 0;
    exp_en_on_err = (hole_at < 0);
    dest_addr     = d;
    src_addr      = s;
    len_type      = lt;
    @(posedge clk);
    #1 tx_start = 1'b1;
    @(posedge clk);
    #1 tx_start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", {63'd0, busy}, 64'd1);
  endtask

  task automatic frame_finish(input int exp_xfers, input int exp_err);
    int t = 0;
    while (busy !== 1'b0 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk("busy_clears", {63'd0, (t < 20000)}, 64'd1);
    chk("all_bytes_sent", 64'(exp_q.size()), 64'd0);
    chk("payload_xfers", 64'(xfers), 64'(exp_xfers));
    chk("tx_err_pulses", 64'(err_seen), 64'(exp_err));
    chk("ifg_slots", 64'(ifg_cnt), 64'd12);
    chk("tx_en_idle", {63'd0, tx_en}, 64'd0);
    src_data_q.delete();
    hole = -1;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 tx_start = 1'b1;
    @(posedge clk);
    #1 tx_start = 1'b0;
  endtask

  initial begin
    #1_900_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r1, r2;
    int t, plen;
    #5;
    chk("rst_tx_en", {63'd0, tx_en}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_vld", {63'd0, tx_byte_vld}, 64'd0);
    chk("rst_tx_byte", {56'd0, tx_byte}, 64'd0);
    chk("rst_crc_ctl", {62'd0, crc_en, crc_rst}, 64'd0);
    chk("rst_err_rdy", {62'd0, tx_err, data_rdy}, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);

    // Reference frame: 46-byte ramp, no padding.
    frame_setup(48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'hFFFF, 46, 1'b1, 1'b1, -1);
    frame_finish(46, 0);

    // Short payload padded to the minimum.
    frame_setup(48'h0011_2233_4455, 48'h0200_0000_0002, 16'h0800, 10, 1'b0, 1'b1, -1);
    frame_finish(10, 0);

    // Underrun at payload byte 5.
    frame_setup(48'hA1A2_A3A4_A5A6, 48'hB1B2_B3B4_B5B6, 16'h0040, 20, 1'b0, 1'b1, 5);
    frame_finish(5, 1);

    // Reset during SRC_ADDR, then a clean frame.
    frame_setup(48'h1234_5678_9ABC, 48'hDEF0_1234_5678, 16'h0100, 60, 1'b0, 1'b1, -1);
    t = 0;
    while (bytes_popped < 16 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("reach_src_addr", {63'd0, (t < 2000)}, 64'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_tx_en", {63'd0, tx_en}, 64'd0);
    chk("async_rst_busy", {63'd0, busy}, 64'd0);
    chk("async_rst_vld", {63'd0, tx_byte_vld}, 64'd0);
    exp_q.delete();
    src_data_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    frame_setup(48'h1234_5678_9ABC, 48'hDEF0_1234_5678, 16'h0100, 60, 1'b0, 1'b1, -1);
    frame_finish(60, 0);

    // Starts during PAYLOAD and IFG are ignored.
    frame_setup(48'h0A0B_0C0D_0E0F, 48'h0102_0304_0506, 16'h0032, 50, 1'b0, 1'b1, -1);
    fork
      frame_finish(50, 0);
      begin
        t = 0;
        while (bytes_popped < 30 && t < 5000) begin
          @(negedge clk);
          t++;
        end
        chk("reach_payload", {63'd0, (t < 5000)}, 64'd1);
        pulse_start();
        t = 0;
        while (!(ifg_cnt >= 3 && busy && !tx_en) && t < 5000) begin
          @(negedge clk);
          t++;
        end
        chk("reach_ifg", {63'd0, (t < 5000)}, 64'd1);
        pulse_start();
      end
    join
    repeat (300) @(negedge clk);
    chk("no_queued_frame", {63'd0, busy}, 64'd0);

    // Oversize stream without data_last: truncated at 1500 with an error.
    frame_setup(48'hCAFE_0000_BEEF, 48'h0200_0000_0003, 16'h05DC, 1501, 1'b0, 1'b0, -1);
    frame_finish(1500, 1);

    // Random back-to-back frames, each started right after busy falls.
    for (int n = 0; n < 4; n++) begin
      r1 = {$urandom, $urandom};
      r2 = {$urandom, $urandom};
      plen = $urandom_range(80, 1);
      frame_setup(r1[47:0], r2[47:0], r1[63:48], plen, 1'b0, 1'b1, -1);
      frame_finish(plen, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
